// File: rtl/dff_mem_pkg.sv
// Shared types and helpers for the flop-based scratch RAM controller.
package dff_mem_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dff_ram_ctrl_if.sv
// Request/response bus of dff_ram_ctrl; master drives requests, slave answers.
interface dff_ram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NB     = DATA_W / 8;

  // A request transfers at a rising edge where req_valid && req_ready; the
  // master holds req_* stable while req_valid is high and not yet accepted.
  // rsp_valid is a one-cycle pulse per accepted read; rsp_rdata/rsp_err hold.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [NB-1:0]     req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dff_ram_array.sv
// Flop storage with byte-enable write port and combinational read.
// DFF_RAM_PARITY_EN adds one even-parity bit per byte and a read-side check.
module dff_ram_array
  import dff_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/BYTE_W-1:0] wbe,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rpar_err
);
  localparam int NB = DATA_W / BYTE_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata = mem[raddr];

`ifdef DFF_RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];

  // Untouched lanes keep their old parity, so this matches the merged word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) par[waddr][i] <= byte_parity(wdata[i*BYTE_W +: BYTE_W]);
      end
    end
  end

  always_comb begin
    rpar_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (byte_parity(rdata[i*BYTE_W +: BYTE_W]) != par[raddr][i]) rpar_err = 1'b1;
    end
  end
`else
  assign rpar_err = 1'b0;
`endif

endmodule

// File: rtl/dff_ram_ctrl.sv
// Scratch RAM controller: clear sequencer, valid/ready request port and a
// registered read response. DFF_RAM_PARITY_EN enables per-byte parity checks.
module dff_ram_ctrl
  import dff_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           clear_start,
  output logic           busy,
  output state_t         dbg_state,
  dff_ram_ctrl_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NB     = DATA_W / BYTE_W;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              in_range, accept, rd_accept;
  logic              mem_we, par_err;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [NB-1:0]     mem_wbe;
  logic              rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign in_range      = {1'b0, bus.req_addr} < DEPTH_X;
  assign bus.req_ready = (state_q == IDLE) && ena && !clear_start;
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.req_we;
  assign busy          = (state_q == CLEAR);
  assign dbg_state     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (ena) begin
      case (state_q)
        CLEAR: begin
          ptr_d = ptr_q + ADDR_W'(1);
          if (ptr_q == LAST) begin
            state_d = IDLE;
            ptr_d   = '0;
          end
        end
        IDLE: begin
          if (clear_start) begin
            state_d = CLEAR;
            ptr_d   = '0;
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  // The sweep owns the write port while clearing; requests cannot be accepted then.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.req_addr;
    mem_wdata = bus.req_wdata;
    mem_wbe   = bus.req_be;
    if (state_q == CLEAR) begin
      mem_we    = ena;
      mem_waddr = ptr_q;
      mem_wdata = '0;
      mem_wbe   = '1;
    end else begin
      mem_we = accept && bus.req_we && in_range;
    end
  end

  dff_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk      (clk),
    .we       (mem_we),
    .waddr    (mem_waddr),
    .wdata    (mem_wdata),
    .wbe      (mem_wbe),
    .raddr    (bus.req_addr),
    .rdata    (mem_rdata),
    .rpar_err (par_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rd_accept;
      if (rd_accept) begin
        rsp_rdata_q <= in_range ? mem_rdata : '0;
        rsp_err_q   <= !in_range || par_err;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dff_ram_ctrl.sv
// Bench for dff_ram_ctrl at DATA_W=32, DEPTH=12 (byte lanes and out-of-range
// addresses); the parity section is built only with DFF_RAM_PARITY_EN.
module tb_dff_ram_ctrl;
  import dff_mem_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 12;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NB     = DATA_W / 8;

  logic   clk = 1'b0;
  logic   rst, ena, clear_start, busy;
  state_t dbg_state;

  dff_ram_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  dff_ram_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .clear_start (clear_start),
    .busy        (busy),
    .dbg_state   (dbg_state),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Reference model: word contents, remaining sweep cycles, pending responses.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              ref_bad [DEPTH];
  int                sweep_left = DEPTH;
  logic              exp_valid  = 1'b0;
  logic [DATA_W-1:0] exp_hold   = '0;
  logic [DATA_W:0]   exp_q [$];
  int                errors = 0;
  int                checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_bad[i] = 1'b0;
    end
  endtask

  // One clock: drive, check ready, clock, update model, check outputs.
  task automatic step(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [NB-1:0] be,
                      input logic en, input logic clr, input logic r);
    logic ready_exp, acc;
    logic [DATA_W:0] e;
    bus.req_valid = v;  bus.req_we = we;  bus.req_addr = a;
    bus.req_wdata = d;  bus.req_be = be;
    ena = en;  clear_start = clr;  rst = r;
    #1;
    ready_exp = (sweep_left == 0) && en && !clr;
    if (!r) check("req_ready", bus.req_ready, ready_exp);
    acc = v && ready_exp && !r;
    @(posedge clk);
    exp_valid = 1'b0;
    if (r) begin
      sweep_left = DEPTH;
      exp_hold   = '0;
      zero_model();
      exp_q.delete();
    end else begin
      if (en) begin
        if (sweep_left > 0) sweep_left--;
        else if (clr) begin
          sweep_left = DEPTH;
          zero_model();
        end
      end
      if (acc && we && a < DEPTH) begin
        for (int b = 0; b < NB; b++)
          if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        if (be[0]) ref_bad[a] = 1'b0;
      end else if (acc && !we) begin
        exp_valid = 1'b1;
        if (a < DEPTH) exp_q.push_back({ref_bad[a], ref_mem[a]});
        else           exp_q.push_back({1'b1, {DATA_W{1'b0}}});
      end
    end
    #1;
    check("busy", busy, sweep_left > 0);
    check("dbg_state", dbg_state, (sweep_left > 0) ? CLEAR : IDLE);
    check("rsp_valid", bus.rsp_valid, exp_valid);
    if (exp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_hold = e[DATA_W-1:0];
      check("rsp_err", bus.rsp_err, e[DATA_W]);
    end
    check("rsp_rdata", bus.rsp_rdata, exp_hold);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    step(1'b1, 1'b1, a, d, be, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic rd(input logic [ADDR_W-1:0] a);
    step(1'b1, 1'b0, a, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // Counts enabled cycles until busy falls; clear_start pulses at cycle clr_at.
  task automatic count_sweep(input int clr_at, input string name);
    int n = 0;
    for (int i = 0; i < 4 * DEPTH && busy; i++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, (i == clr_at), 1'b0);
      n++;
    end
    check({name, "_timeout"}, busy, 1'b0);
    check({name, "_len"}, n, DEPTH);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && busy; i++) idle();
    check("drain_timeout", busy, 1'b0);
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;
  vec_t tbl [12];

  initial begin
    rst = 1'b1; ena = 1'b0; clear_start = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0;
    zero_model();
    @(posedge clk); #1;

    // Reset state, then the power-up sweep with a clear_start it must ignore.
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    check("reset_busy", busy, 1'b1);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_rdata", bus.rsp_rdata, '0);
    check("reset_rsp_err", bus.rsp_err, 1'b0);
    count_sweep(3, "init_sweep");
    for (int i = 0; i < DEPTH; i++) begin
      rd(ADDR_W'(i));
      check("init_zero", bus.rsp_rdata, '0);
      check("init_zero_err", bus.rsp_err, 1'b0);
    end

    tbl[0]  = '{1'b1, 4'd5,  32'h11223344, 4'hF,    32'h0,        1'b0};
    tbl[1]  = '{1'b1, 4'd5,  32'hFFFFFFFF, 4'b0101, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 4'd5,  32'h0,        4'h0,    32'h11FF33FF, 1'b0};
    tbl[3]  = '{1'b1, 4'd3,  32'h000000A5, 4'hF,    32'h0,        1'b0};
    tbl[4]  = '{1'b0, 4'd3,  32'h0,        4'h0,    32'h000000A5, 1'b0};
    tbl[5]  = '{1'b0, 4'd13, 32'h0,        4'h0,    32'h0,        1'b1};
    tbl[6]  = '{1'b1, 4'd13, 32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
    tbl[7]  = '{1'b1, 4'd7,  32'h12345678, 4'h0,    32'h0,        1'b0};
    tbl[8]  = '{1'b0, 4'd7,  32'h0,        4'h0,    32'h0,        1'b0};
    tbl[9]  = '{1'b1, 4'd11, 32'hCAFEF00D, 4'b1100, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 4'd11, 32'h0,        4'h0,    32'hCAFE0000, 1'b0};
    tbl[11] = '{1'b0, 4'd1,  32'h0,        4'h0,    32'h0,        1'b0};
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 1'b1, 1'b0, 1'b0);
      if (!tbl[i].we) begin
        check("tbl_valid", bus.rsp_valid, 1'b1);
        check("tbl_rdata", bus.rsp_rdata, tbl[i].exp_rdata);
        check("tbl_err", bus.rsp_err, tbl[i].exp_err);
      end
    end
    for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i));

    // ena low: no accept, response drops, data holds.
    wr(4'd6, 32'h0BADF00D, 4'hF);
    rd(4'd6);
    step(1'b1, 1'b0, 4'd6, '0, '0, 1'b0, 1'b0, 1'b0);
    check("ena0_valid", bus.rsp_valid, 1'b0);
    check("ena0_hold", bus.rsp_rdata, 32'h0BADF00D);

    // clear_start beats a same-cycle write; reset mid-sweep restarts it.
    step(1'b1, 1'b1, 4'd6, 32'h55555555, 4'hF, 1'b1, 1'b1, 1'b0);
    check("clr_busy", busy, 1'b1);
    for (int i = 0; i < 7; i++) idle();
    check("mid_sweep_busy", busy, 1'b1);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    count_sweep(-1, "restart_sweep");
    rd(4'd5);
    check("cleared_5", bus.rsp_rdata, '0);
    rd(4'd6);
    check("cleared_6", bus.rsp_rdata, '0);

    // Randomized traffic, including ena gaps and occasional clears.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), ADDR_W'($urandom_range(0, 15)),
           $urandom, NB'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 63) == 0), 1'b0);
    end
    drain();
    for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i));

`ifdef DFF_RAM_PARITY_EN
    wr(4'd2, 32'h0000003C, 4'hF);
    wr(4'd4, 32'h00000055, 4'hF);
    dut.u_array.mem[2][1] = ~dut.u_array.mem[2][1];
    ref_mem[2][1] = ~ref_mem[2][1];
    ref_bad[2] = 1'b1;
    rd(4'd2);
    check("par_flip_err", bus.rsp_err, 1'b1);
    rd(4'd4);
    check("par_clean_err", bus.rsp_err, 1'b0);
`endif

    idle();
    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
